// File: rtl/action_ram_arbiter_if.sv
// Requester-side bus of the action RAM arbiter: policy lookup port (a_*) and
// learning read-modify-write port (b_*).
interface action_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_delta;
    logic              b_gnt;
    logic              b_done;
    logic [DATA_W-1:0] b_result;
    logic              b_sat;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, b_delta,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_done, b_result, b_sat
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, b_delta,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_done, b_result, b_sat
    );
endinterface

// File: rtl/action_ram_arbiter.sv
// Serialises policy reads (A) and learning RMW updates (B) onto the action RAM.
// Define ACTION_SAT_EN to saturate B results instead of wrapping.
module action_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    action_ram_arbiter_if.slave req_bus,
    output logic                busy,
    output logic [ADDR_W-1:0]   ram_read_address,
    output logic [ADDR_W-1:0]   ram_write_address,
    output logic [DATA_W-1:0]   ram_d_in,
    output logic                ram_write_enable,
    input  logic [DATA_W-1:0]   ram_d_out
);
    typedef enum logic [2:0] {IDLE, RD, CAP, RESP, WR} state_t;

    state_t            state;
    state_t            next_state;
    logic              grant_a;
    logic              grant_b;
    logic              last_b;
    logic              owner_b;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] delta_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_result_q;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] sum;
    logic              sat;

    always_comb begin
        next_state = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        unique case (state)
            IDLE: begin
                if (reset_n) begin
                    // last_b breaks a tie in favour of whoever was not served last
                    grant_a = req_bus.a_req && (!req_bus.b_req || last_b);
                    grant_b = req_bus.b_req && !grant_a;
                    if (grant_a || grant_b) next_state = RD;
                end
            end
            RD:      next_state = CAP;
            CAP:     next_state = owner_b ? WR : RESP;
            RESP:    next_state = IDLE;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign sum_ext = {ram_d_out[DATA_W-1], ram_d_out} + {delta_q[DATA_W-1], delta_q};

`ifdef ACTION_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic sat_q;

    // Disagreeing top two bits of the extended sum mean signed overflow
    always_comb begin
        sat = sum_ext[DATA_W] != sum_ext[DATA_W-1];
        sum = sum_ext[DATA_W-1:0];
        if (sat) sum = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
    end

    always_ff @(posedge clock) begin
        if (!reset_n)                      sat_q <= 1'b0;
        else if (state == CAP && owner_b)  sat_q <= sat;
    end

    assign req_bus.b_sat = (state == WR) && reset_n && sat_q;
`else
    assign sat = 1'b0;
    assign sum = sum_ext[DATA_W-1:0];
    assign req_bus.b_sat = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= IDLE;
            last_b            <= 1'b1;
            owner_b           <= 1'b0;
            addr_q            <= '0;
            delta_q           <= '0;
            ram_read_address  <= '0;
            ram_write_address <= '0;
            ram_d_in          <= '0;
            a_rdata_q         <= '0;
            b_result_q        <= '0;
        end else begin
            state <= next_state;
            if (grant_a || grant_b) begin
                last_b           <= grant_b;
                owner_b          <= grant_b;
                addr_q           <= grant_b ? req_bus.b_addr : req_bus.a_addr;
                delta_q          <= req_bus.b_delta;
                ram_read_address <= grant_b ? req_bus.b_addr : req_bus.a_addr;
            end
            if (state == CAP) begin
                if (owner_b) begin
                    ram_write_address <= addr_q;
                    ram_d_in          <= sum;
                    b_result_q        <= sum;
                end else begin
                    a_rdata_q <= ram_d_out;
                end
            end
        end
    end

    // Strobes are qualified by reset_n so a reset cycle never writes or responds
    assign req_bus.a_gnt    = grant_a;
    assign req_bus.b_gnt    = grant_b;
    assign req_bus.a_rvalid = (state == RESP) && reset_n;
    assign req_bus.b_done   = (state == WR) && reset_n;
    assign req_bus.a_rdata  = a_rdata_q;
    assign req_bus.b_result = b_result_q;
    assign ram_write_enable = (state == WR) && reset_n;
    assign busy             = (state != IDLE);

endmodule
